param_fifo: RTL
===============

# param_fifo

Synchronous, parametrised single-clock FIFO and next-generation buffer for the lab datapaths. Storage is an internal register array of 2**depth words, with occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. A compile-time option selects between a registered-read output and a first-word-fall-through output.

## Interface
- depth, 4, address width in bits; capacity is 2**depth words (depth ≥ 1)
- width, 8, data word width in bits (width ≥ 1)
- af_thresh, 2**depth - 2, almost_full asserts when count ≥ af_thresh (legal range 1..2**depth)
- ae_thresh, 1, almost_empty asserts when count ≤ ae_thresh (legal range 0..2**depth-1)
- clk  input  1  sole clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately; deassertion is sampled on clk
- flush  input  1  synchronous clear of contents, pointers and error flags
- write  input  1  push request for inputBus
- read  input  1  pop request
- inputBus  input  width  write data
- outputBus  output  width  read data
- empty  output  1  count == 0
- full  output  1  count == 2**depth
- almost_empty  output  1  count ≤ ae_thresh
- almost_full  output  1  count ≥ af_thresh
- count  output  depth+1  current occupancy, 0..2**depth
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: a read was ignored

## Operation
- Pointers: rdAddr and wrAddr, each depth bits, wrap modulo 2**depth; count is held as its own register, not derived from the pointers.
- Accepted write (write & (!full | read)): store inputBus at wrAddr; wrAddr+1.
- Accepted read (read & !empty): rdAddr+1.
- Read and write together, not empty: both are accepted; count is unchanged.
- Read and write together, full: both are accepted; count stays at 2**depth; full stays 1.
- Read and write together, empty: only the write is accepted; count becomes 1; underflow is set.
- Write while full with no read: data is dropped; pointers and count are unchanged; overflow is set.
- Read while empty: ignored; underflow is set.
- flush = 1: on that edge count=0, rdAddr=wrAddr=0, overflow=underflow=0.
  - read and write are ignored on that edge.
  - Memory contents are not cleared.
  - outputBus goes to 0 on that edge.
- overflow and underflow clear only on reset or flush.
- Storage array is not reset; contents are undefined until written.
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, outputBus=0, both pointers 0.

## Timing
- All flags and count are registered and reflect state after the most recent edge.
  - Example: the first write sets empty=0 one edge after the write is sampled.
- Write-to-read latency: a word written on edge N can be popped with read sampled on edge N+1.
- Registered-read mode (macro undefined):
  - On an accepted read, outputBus loads mem[rdAddr] at that edge and holds until the next accepted read or flush.
  - Read data latency is 1 cycle.
- FWFT mode (macro defined): outputBus = mem[rdAddr] combinationally whenever empty=0, and 0 when empty=1.
  - The head word is visible the cycle after it is written.
  - An accepted read advances to the next word on the same edge.
- Async reset must take effect without a clock edge. This includes reset asserted mid-transfer.

## Configuration
- FIFO_FWFT_EN: when defined, outputBus is first-word-fall-through, with 0-cycle visibility of the head.
- When not defined, outputBus is a register loaded on accepted reads, with 1-cycle latency, holding the last popped word.
- Flag, count and error behaviour is identical in both modes.

## Test plan
All scenarios use depth=2, width=8, af_thresh=3, ae_thresh=1.
- Reset:
  - Stimulus: reset=0 asserted mid-cycle after 2 writes.
  - Required: count=0, empty=1, almost_empty=1, outputBus=0 immediately, with no clk edge.
- Fill and overflow:
  - Stimulus: write 8'h11, 8'h22, 8'h33, 8'h44, then write 8'h55.
  - Required: almost_full=1 at count=3; full=1 at count=4; 8'h55 dropped; overflow=1; count stays 4.
- Drain and underflow:
  - Stimulus: from full, 5 consecutive reads.
  - Required: outputs 8'h11, 8'h22, 8'h33, 8'h44 in order (1-cycle lag in registered mode, immediate in FWFT); empty=1 after the 4th read; the 5th read sets underflow=1.
- Simultaneous read/write:
  - At count=4, read+write 8'hAA: count stays 4, full stays 1, head advances.
  - At count=0, read+write 8'hBB: count=1, underflow=1.
- Wrap-around:
  - Stimulus: 10 interleaved write/read pairs with data 8'h00..8'h09.
  - Required: data out matches in order across pointer wrap; count never exceeds 1.
- Flush:
  - Stimulus: at count=3 with overflow=1, pulse flush together with write=1.
  - Required: next edge count=0, empty=1, overflow=0, the write is ignored, outputBus=0.

Source files
------------

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised single-clock FIFO with occupancy flags and sticky errors
//
// Purpose:
//   Register-array FIFO of 2**depth words of width bits. Occupancy is held as
//   its own counter. Flags and sticky overflow/underflow are registered. A
//   synchronous flush clears pointers, count and error flags. Memory contents
//   are not reset.
//
// Optional feature (macro FIFO_FWFT_EN):
//   defined   - outputBus shows the head word combinationally while not empty
//               (first-word-fall-through), 0 when empty.
//   undefined - outputBus is a register loaded on each accepted read and held
//               until the next accepted read or flush.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   flush        in   synchronous clear (read/write ignored on that edge)
//   write        in   push request for inputBus
//   read         in   pop request
//   inputBus     in   write data [width]
//   outputBus    out  read data [width]
//   empty        out  count == 0
//   full         out  count == 2**depth
//   almost_empty out  count <= ae_thresh
//   almost_full  out  count >= af_thresh
//   count        out  occupancy [depth+1]
//   overflow     out  sticky: a write was dropped
//   underflow    out  sticky: a read was ignored

module param_fifo #(
  parameter int depth     = 4,
  parameter int width     = 8,
  parameter int af_thresh = 2**depth - 2,
  parameter int ae_thresh = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic             read,
  input  logic [width-1:0] inputBus,
  output logic [width-1:0] outputBus,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [depth:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int               CAP      = 2**depth;
  localparam logic [depth-1:0] PTR_ONE  = depth'(1);
  localparam logic [depth:0]   CNT_ONE  = (depth+1)'(1);
  localparam logic [depth:0]   CNT_FULL = (depth+1)'(CAP);

  logic [width-1:0] mem_q [CAP];

  logic [depth-1:0] rd_ptr_q, rd_ptr_d;
  logic [depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth:0]   count_q,  count_d;
  logic             empty_q,  empty_d;
  logic             full_q,   full_d;
  logic             ae_q,     ae_d;
  logic             af_q,     af_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;

  logic             wr_acc;
  logic             rd_acc;

  // A write into a full FIFO is still accepted when a read frees the slot on
  // the same edge. Flush suppresses both requests.
  assign wr_acc = write & (~full_q | read) & ~flush;
  assign rd_acc = read & ~empty_q & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (write & full_q & ~read) ovf_d = 1'b1;
      if (read & empty_q)         unf_d = 1'b1;
    end
  end

  // Flags are registered from the next count so they match count every cycle.
  always_comb begin
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    ae_d    = (int'(count_d) <= ae_thresh);
    af_d    = (int'(count_d) >= af_thresh);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset; the reset term only keeps writes out while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && reset) mem_q[wr_ptr_q] <= inputBus;
  end

`ifdef FIFO_FWFT_EN
  assign outputBus = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [width-1:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (flush)       out_d = '0;
    else if (rd_acc) out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign outputBus = out_q;
`endif

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
